// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC holder, imem req/ack fetcher and decode valid/ready presenter
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCin,
  output logic [31:0] PC,
  output logic [31:0] PCp4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_count,
  output logic        fetch_err,
  output logic [1:0]  err_code
);
  typedef enum logic [1:0] {FETCH = 2'b00, HOLD = 2'b01, ERR = 2'b10} state_t;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d, ins_q, ins_d, count_q, count_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    count_d = count_q;
    wait_d  = wait_q;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      FETCH:
        if (imem_ack) begin
          ins_d   = imem_rdata;
          wait_d  = '0;
          state_d = HOLD;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          wait_d  = '0;
          state_d = ERR;
          err_d   = 1'b1;
          code_d  = 2'b01;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      HOLD:
        if (ins_ready) begin
          count_d = count_q + 32'd1;
          if (PCin[1:0] == 2'b00) begin
            pc_d    = PCin;
            state_d = FETCH;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = 2'b10;
          end
        end
      ERR: ;
      // the unused code 11 is treated like a stuck fetch
      default: begin
        state_d = ERR;
        err_d   = 1'b1;
        code_d  = 2'b01;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ins_q   <= '0;
      count_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  // reset state is FETCH, so the request is gated by reset to drop it at once
  assign imem_req  = rst_n && state_q == FETCH;
  assign ins_valid = state_q == HOLD;
  assign PC        = pc_q;
  assign PCp4      = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign ins       = ins_q;
  assign ins_count = count_q;
  assign fetch_err = err_q;
  assign err_code  = code_q;
endmodule
